// File: rtl/fp_div_seq_if.sv
// rtl/fp_div_seq_if.sv - operand/result bus between the arithmetic unit and the FP divider
// Purpose: bundles the start/valid handshake, operand buses and status flags.
// Signals:
//   start        requester -> divider  request, sampled only while the divider is idle
//   A, B         requester -> divider  dividend / divisor {sign, exp, frac}
//   busy         divider -> requester  high from the accepting edge until valid
//   valid        divider -> requester  one-cycle pulse when Resultado and flags update
//   Resultado    divider -> requester  quotient, held until the next valid
//   invalid, div_by_zero, overflow, underflow  divider -> requester  status flags
// Modports: master = requester side, slave = divider side.
interface fp_div_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         valid;
  logic [W-1:0] Resultado;
  logic         invalid;
  logic         div_by_zero;
  logic         overflow;
  logic         underflow;

  modport master (
    output start, A, B,
    input  busy, valid, Resultado, invalid, div_by_zero, overflow, underflow
  );

  modport slave (
    input  start, A, B,
    output busy, valid, Resultado, invalid, div_by_zero, overflow, underflow
  );
endinterface

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE-754 binary32 divider, one quotient bit per cycle
// Purpose: divides A by B with a restoring significand divider. Special operands
//   (NaN, infinity, zero/denormal) bypass the divider and finish in 2 cycles;
//   normal operands finish in MAN_W+5 cycles. Denormal inputs are treated as zero
//   and results never become denormal (flush to zero).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   fp_div_seq_if.slave: start, A, B in; busy, valid, Resultado,
//         invalid, div_by_zero, overflow, underflow out
// Build option: FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even;
//   without it the result is truncated toward zero.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic        clk,
  input  logic        rst,
  fp_div_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;        // significand with hidden one
  localparam int REM_W = MAN_W + 2;        // partial remainder never exceeds 2*divisor
  localparam int Q_W   = MAN_W + 3;        // 1 integer bit + MAN_W+2 fraction bits
  localparam int E_W   = EXP_W + 2;        // signed working exponent
  localparam int CNT_W = $clog2(Q_W);

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [E_W-1:0] E_INF  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIVIDE,
    S_NORM,
    S_SPECIAL,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic             sign_q, sign_d;
  logic [EXP_W-1:0] ea_q, ea_d;
  logic [EXP_W-1:0] eb_q, eb_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SIG_W-1:0] dvs_q, dvs_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     spec_res_q, spec_res_d;
  logic             spec_inv_q, spec_inv_d;
  logic             spec_dbz_q, spec_dbz_d;
  logic [W-1:0]     res_q, res_d;
  logic             inv_q, inv_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  // ---------------------------------------------------------------------------
  // Operand classification on the live input bus (used only at accept)
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             sign_in;
  logic             a_zero, a_inf, a_nan;
  logic             b_zero, b_inf, b_nan;

  assign exp_a   = bus.A[W-2 -: EXP_W];
  assign exp_b   = bus.B[W-2 -: EXP_W];
  assign frac_a  = bus.A[MAN_W-1:0];
  assign frac_b  = bus.B[MAN_W-1:0];
  assign sign_in = bus.A[W-1] ^ bus.B[W-1];

  // Denormals (exp == 0) count as zero regardless of their fraction.
  assign a_zero = (exp_a == '0);
  assign b_zero = (exp_b == '0);
  assign a_inf  = (&exp_a) && (frac_a == '0);
  assign b_inf  = (&exp_b) && (frac_b == '0);
  assign a_nan  = (&exp_a) && (frac_a != '0);
  assign b_nan  = (&exp_b) && (frac_b != '0);

  logic         is_special;
  logic [W-1:0] sp_res;
  logic         sp_inv;
  logic         sp_dbz;

  // Checked in priority order; the first matching rule wins.
  always_comb begin
    is_special = 1'b1;
    sp_res     = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    sp_inv     = 1'b0;
    sp_dbz     = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      sp_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      sp_res = {sign_in, {(W-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring division step
  // ---------------------------------------------------------------------------
  logic [REM_W:0] diff;
  logic           borrow;

  assign diff   = {1'b0, rem_q} - {2'b00, dvs_q};
  assign borrow = diff[REM_W];

  // ---------------------------------------------------------------------------
  // Normalise, round and range-check the finished quotient
  // ---------------------------------------------------------------------------
  logic signed [E_W-1:0] e_raw, e_n, e_fin;
  logic [SIG_W-1:0]      sig;
  logic [SIG_W:0]        sig_r;
  logic [MAN_W-1:0]      frac_n;
  logic                  guard, rest, sticky, inc, carry;
  logic                  ovf_n, unf_n;
  logic [W-1:0]          norm_res;

  always_comb begin
    e_raw  = {2'b00, ea_q} - {2'b00, eb_q} + E_W'(BIAS);
    sticky = |rem_q;
    // Ratio of two [1,2) significands lies in (0.5,2): at most one left shift.
    if (quo_q[Q_W-1]) begin
      sig   = quo_q[Q_W-1 -: SIG_W];
      guard = quo_q[1];
      rest  = quo_q[0] | sticky;
      e_n   = e_raw;
    end else begin
      sig   = quo_q[Q_W-2 -: SIG_W];
      guard = quo_q[0];
      rest  = sticky;
      e_n   = e_raw - E_W'(1);
    end
    inc    = RNE & guard & (rest | sig[0]);
    sig_r  = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
    carry  = sig_r[SIG_W];
    // A carry out leaves 10.00..0; shifting right gives 1.00..0.
    frac_n = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    e_fin  = e_n + {{(E_W-1){1'b0}}, carry};
    ovf_n  = (e_fin >= E_INF);
    unf_n  = (e_fin <= E_ZERO);
    if (ovf_n) begin
      norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf_n) begin
      norm_res = {sign_q, {(W-1){1'b0}}};
    end else begin
      norm_res = {sign_q, e_fin[EXP_W-1:0], frac_n};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    spec_res_d = spec_res_q;
    spec_inv_d = spec_inv_q;
    spec_dbz_d = spec_dbz_q;
    res_d      = res_q;
    inv_d      = inv_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d     = 1'b1;
          sign_d     = sign_in;
          ea_d       = exp_a;
          eb_d       = exp_b;
          rem_d      = {1'b0, 1'b1, frac_a};
          dvs_d      = {1'b1, frac_b};
          quo_d      = '0;
          cnt_d      = '0;
          spec_res_d = sp_res;
          spec_inv_d = sp_inv;
          spec_dbz_d = sp_dbz;
          state_d    = is_special ? S_SPECIAL : S_DIVIDE;
        end
      end

      S_DIVIDE: begin
        if (!borrow) begin
          rem_d = diff[REM_W-1:0] << 1;
        end else begin
          rem_d = rem_q << 1;
        end
        quo_d = {quo_q[Q_W-2:0], ~borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        res_d   = norm_res;
        inv_d   = 1'b0;
        dbz_d   = 1'b0;
        ovf_d   = ovf_n;
        unf_d   = unf_n;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end

      S_SPECIAL: begin
        res_d   = spec_res_q;
        inv_d   = spec_inv_q;
        dbz_d   = spec_dbz_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_res_q <= '0;
      spec_inv_q <= 1'b0;
      spec_dbz_q <= 1'b0;
      res_q      <= '0;
      inv_q      <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      spec_res_q <= spec_res_d;
      spec_inv_q <= spec_inv_d;
      spec_dbz_q <= spec_dbz_d;
      res_q      <= res_d;
      inv_q      <= inv_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.Resultado   = res_q;
  assign bus.invalid     = inv_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - self-checking bench for fp_div_seq
module tb_fp_div_seq;
  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  fp_div_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_div_seq #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact real-number quotient of the significands, rounded from the
  // exact remainder; flags ordered {invalid, div_by_zero, overflow, underflow}.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output int lat);
    logic            s;
    logic [7:0]      ea, eb;
    logic [22:0]     fa, fb;
    logic            an, ai, az, bn, bi, bz;
    longint unsigned ma, mb, num, sig, rem;
    int              e;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    an = (ea == 8'hFF) && (fa != 0);
    ai = (ea == 8'hFF) && (fa == 0);
    az = (ea == 8'h00);
    bn = (eb == 8'hFF) && (fb != 0);
    bi = (eb == 8'hFF) && (fb == 0);
    bz = (eb == 8'h00);
    f   = 4'b0000;
    lat = 2;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (ai) begin
      r = {s, 8'hFF, 23'h0};
    end else if (bz) begin
      r = {s, 8'hFF, 23'h0}; f = 4'b0100;
    end else if (az || bi) begin
      r = {s, 31'h0};
    end else begin
      lat = 28;
      ma = 64'h800000 + fa;
      mb = 64'h800000 + fb;
      e  = int'(ea) - int'(eb) + 127;
      if (ma < mb) begin
        ma = ma * 2;
        e  = e - 1;
      end
      num = ma << 23;
      sig = num / mb;
      rem = num % mb;
`ifdef FP_DIV_ROUND_NEAREST_EN
      if ((2 * rem > mb) || ((2 * rem == mb) && sig[0])) sig = sig + 1;
`endif
      if (sig == 64'h1000000) begin
        sig = 64'h800000;
        e   = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0001;
      end else begin
        r = {s, e[7:0], sig[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    case (k)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; f = 23'h0; end
      2:       begin e = 8'hFF; f = f | 23'h1; end
      3:       e = 8'($urandom_range(1, 4));
      4:       e = 8'($urandom_range(250, 254));
      5:       begin e = 8'($urandom_range(1, 254)); f = 23'h0; end
      6, 7:    e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Called at a negedge with the divider idle. Returns at the negedge of the
  // valid cycle; lat counts cycles with the cycle after the accept edge as 1.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] flg,
                       output int lat, output bit busy_at_valid,
                       output bit busy_held, output bit ok);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    lat = 1; ok = 1'b0; busy_held = 1'b1; busy_at_valid = 1'b1;
    res = '0; flg = '0;
    while (!ok && lat <= 100) begin
      @(negedge clk);
      if (bus.valid) begin
        ok            = 1'b1;
        res           = bus.Resultado;
        flg           = {bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow};
        busy_at_valid = bus.busy;
      end else begin
        if (!bus.busy) busy_held = 1'b0;
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vecs++; if (bus.valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    vecs++; if (bus.Resultado !== 32'h0) begin errs++; $display("FAIL reset_result: got %h want 00000000", bus.Resultado); end
    vecs++;
    if ({bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_flags: got %b want 0000", {bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [31:0] tr [6];
    logic [3:0]  tf [6];
    int          tl [6];
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    bit          bav, bh, ok;
    ta = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000, 32'h00800000};
    tb = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h7F000000};
`ifdef FP_DIV_ROUND_NEAREST_EN
    tr = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
`else
    tr = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
`endif
    tf = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
    tl = '{28, 28, 2, 2, 28, 28};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      do_op(ta[i], tb[i], res, flg, lat, bav, bh, ok);
      vecs++; if (!ok) begin errs++; $display("FAIL dir%0d_timeout: no valid within 100 cycles", i); end
      vecs++; if (res !== tr[i]) begin errs++; $display("FAIL dir%0d_result: got %h want %h", i, res, tr[i]); end
      vecs++; if (flg !== tf[i]) begin errs++; $display("FAIL dir%0d_flags: got %b want %b", i, flg, tf[i]); end
      vecs++; if (lat !== tl[i]) begin errs++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
      vecs++; if (bav !== 1'b0) begin errs++; $display("FAIL dir%0d_busy_at_valid: got %b want 0", i, bav); end
      vecs++; if (bh !== 1'b1) begin errs++; $display("FAIL dir%0d_busy_held: got %b want 1", i, bh); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, er;
    logic [3:0]  flg, ef;
    int          lat, el;
    bit          bav, bh, ok;
    for (int i = 0; i < 150; i++) begin
      a = rand_op();
      b = rand_op();
      ref_div(a, b, er, ef, el);
      @(negedge clk);
      do_op(a, b, res, flg, lat, bav, bh, ok);
      vecs++;
      if (!ok || res !== er) begin
        errs++; $display("FAIL rand%0d_result: %h/%h got %h want %h", i, a, b, res, er);
      end
      vecs++; if (flg !== ef) begin errs++; $display("FAIL rand%0d_flags: %h/%h got %b want %b", i, a, b, flg, ef); end
      vecs++; if (lat !== el) begin errs++; $display("FAIL rand%0d_latency: %h/%h got %0d want %0d", i, a, b, lat, el); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] res, er;
    logic [3:0]  flg, ef;
    int          lat, el;
    bit          bav, bh, ok;
    a = '{32'h40C00000, 32'hBF800000, rand_op()};
    b = '{32'h40000000, 32'h00000000, 32'h3F800000 | (32'($urandom) & 32'h007FFFFF)};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ref_div(a[i], b[i], er, ef, el);
      do_op(a[i], b[i], res, flg, lat, bav, bh, ok);
      vecs++; if (!ok || res !== er) begin errs++; $display("FAIL b2b%0d_result: got %h want %h", i, res, er); end
      vecs++; if (flg !== ef) begin errs++; $display("FAIL b2b%0d_flags: got %b want %b", i, flg, ef); end
      vecs++; if (lat !== el) begin errs++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, el); end
      @(negedge clk);
      vecs++; if (bus.valid !== 1'b0) begin errs++; $display("FAIL b2b%0d_valid_pulse: got %b want 0", i, bus.valid); end
      vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b%0d_idle_busy: got %b want 0", i, bus.busy); end
    end
  endtask

  task automatic test_ignored_start();
    int          n, nvalid, lat;
    bit          busy_held, busy_at_valid;
    logic [31:0] res;
    @(negedge clk);
    bus.A = 32'h40C00000; bus.B = 32'h40000000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = 32'h3F800000; bus.B = 32'h40400000;
    n = 1; nvalid = 0; busy_held = 1'b1; busy_at_valid = 1'b1; lat = 0; res = '0;
    while (n <= 70) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.valid) begin
        nvalid++;
        if (nvalid == 1) begin
          lat = n; res = bus.Resultado; busy_at_valid = bus.busy;
        end
        bus.start = 1'b1; bus.A = 32'h7F000000; bus.B = 32'h3E800000;
      end else if (nvalid == 0 && !bus.busy) begin
        busy_held = 1'b0;
      end
      if (n == 5) begin
        bus.start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h40400000;
      end
      @(posedge clk);
      n++;
    end
    bus.start = 1'b0;
    vecs++; if (nvalid !== 1) begin errs++; $display("FAIL ign_valid_count: got %0d want 1", nvalid); end
    vecs++; if (res !== 32'h40400000) begin errs++; $display("FAIL ign_result: got %h want 40400000", res); end
    vecs++; if (lat !== 28) begin errs++; $display("FAIL ign_latency: got %0d want 28", lat); end
    vecs++; if (busy_held !== 1'b1) begin errs++; $display("FAIL ign_busy_held: got %b want 1", busy_held); end
    vecs++; if (busy_at_valid !== 1'b0) begin errs++; $display("FAIL ign_busy_at_valid: got %b want 0", busy_at_valid); end
  endtask

  task automatic test_reset_midop();
    int          nvalid, lat;
    logic [31:0] res;
    logic [3:0]  flg;
    bit          bav, bh, ok;
    @(negedge clk);
    bus.A = 32'h40C00000; bus.B = 32'h40000000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    vecs++; if (bus.valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b want 0", bus.valid); end
    vecs++; if (bus.Resultado !== 32'h0) begin errs++; $display("FAIL rstmid_result: got %h want 00000000", bus.Resultado); end
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    vecs++; if (nvalid !== 0) begin errs++; $display("FAIL rstmid_no_valid: got %0d valids want 0", nvalid); end
    @(negedge clk);
    do_op(32'h40C00000, 32'h40000000, res, flg, lat, bav, bh, ok);
    vecs++; if (!ok || res !== 32'h40400000) begin errs++; $display("FAIL rstmid_after_result: got %h want 40400000", res); end
    vecs++; if (lat !== 28) begin errs++; $display("FAIL rstmid_after_latency: got %0d want 28", lat); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignored_start();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
